// File: rtl/alu_pkg.sv
// Shared command encodings, FSM state type and command-class helpers for the bit-serial ALU driver.
// Used by alu_bit_shifter and alu_serial_driver (optional flag ports: ALU_SERIAL_FLAGS_EN).
package alu_pkg;

   localparam logic [2:0] CMD_ADD  = 3'b000;
   localparam logic [2:0] CMD_SUB  = 3'b001;
   localparam logic [2:0] CMD_XOR  = 3'b010;
   localparam logic [2:0] CMD_SLT  = 3'b011;
   localparam logic [2:0] CMD_AND  = 3'b100;
   localparam logic [2:0] CMD_NAND = 3'b101;
   localparam logic [2:0] CMD_NOR  = 3'b110;
   localparam logic [2:0] CMD_OR   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Subtract and set-less-than run as A + ~B + 1.
   function automatic logic cmd_inverts_b(input logic [2:0] cmd);
      return (cmd == CMD_SUB) || (cmd == CMD_SLT);
   endfunction

   function automatic logic cmd_is_arith(input logic [2:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SLT);
   endfunction

endpackage

// File: rtl/alu_bit_shifter.sv
// Operand shift pair plus result collector for the bit-serial ALU: presents bit 0 of each operand,
// shifts right once per slice step, and shifts each result bit in at the MSB so the word lands LSB-aligned.
module alu_bit_shifter
   import alu_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] a_word,
   input  logic [WIDTH-1:0] b_word,
   input  logic             res_bit,
   output logic             a_bit,
   output logic             b_bit,
   output logic [IDXW-1:0]  idx,
   output logic             last,
   output logic [WIDTH-1:0] res_word
);

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic [IDXW-1:0]  idx_r;

   // Operand/result shift registers and bit index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         res_r <= '0;
         idx_r <= '0;
      end else if (load) begin
         a_r   <= a_word;
         b_r   <= b_word;
         res_r <= '0;
         idx_r <= '0;
      end else if (shift) begin
         a_r   <= {1'b0, a_r[WIDTH-1:1]};
         b_r   <= {1'b0, b_r[WIDTH-1:1]};
         res_r <= {res_bit, res_r[WIDTH-1:1]};
         idx_r <= idx_r + IDXW'(1'b1);
      end else begin
         a_r   <= a_r;
         b_r   <= b_r;
         res_r <= res_r;
         idx_r <= idx_r;
      end
   end

   assign a_bit    = a_r[0];
   assign b_bit    = b_r[0];
   assign idx      = idx_r;
   assign last     = (idx_r == IDXW'(WIDTH - 1));
   assign res_word = res_r;

endmodule

// File: rtl/alu_serial_driver.sv
// Bit-serial controller for a one-bit ALU slice: request in, WIDTH slice steps LSB first, registered response out.
// Define ALU_SERIAL_FLAGS_EN to export rsp_carry / rsp_ovf alongside the result.
module alu_serial_driver
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_cmd,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [2:0]       sl_command,
   output logic             sl_a,
   output logic             sl_b,
   output logic             sl_cin,
   output logic             sl_zin,
   output logic             sl_invtb,
   input  logic             sl_result,
   input  logic             sl_cout,
   input  logic             sl_zout
`ifdef ALU_SERIAL_FLAGS_EN
   ,
   output logic             rsp_carry,
   output logic             rsp_ovf
`endif
);

   localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state_r;
   state_t           state_s;
   logic [2:0]       cmd_r;
   logic             invtb_r;
   logic             carry_r;
   logic             zacc_r;
   logic             cmsb_r;
   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_result_r;
   logic             rsp_zero_r;
   logic             load_s;
   logic             shift_s;
   logic             a_bit_s;
   logic             b_bit_s;
   logic             last_s;
   logic [IDXW-1:0]  idx_s;
   logic [WIDTH-1:0] res_s;
   logic             ovf_s;
   logic             slt_bit_s;
   logic [WIDTH-1:0] fin_result_s;
   logic             fin_zero_s;

   alu_bit_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .shift    (shift_s),
      .a_word   (req_a),
      .b_word   (req_b),
      .res_bit  (sl_result),
      .a_bit    (a_bit_s),
      .b_bit    (b_bit_s),
      .idx      (idx_s),
      .last     (last_s),
      .res_word (res_s)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state, shifter control and slice drive; slice pins stay low outside RUN.
   always_comb begin
      state_s    = state_r;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      sl_command = 3'b000;
      sl_a       = 1'b0;
      sl_b       = 1'b0;
      sl_cin     = 1'b0;
      sl_zin     = 1'b0;
      sl_invtb   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               load_s  = 1'b1;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            shift_s    = 1'b1;
            sl_command = cmd_r;
            sl_a       = a_bit_s;
            sl_b       = b_bit_s;
            sl_invtb   = invtb_r;
            sl_cin     = (idx_s == '0) ? invtb_r : carry_r;
            sl_zin     = (idx_s == '0) ? 1'b0 : zacc_r;
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (rsp_valid_r && rsp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Overflow is the carry into the MSB differing from the carry out; slt corrects the sign bit with it.
   always_comb begin
      ovf_s     = cmd_is_arith(cmd_r) ? (cmsb_r ^ carry_r) : 1'b0;
      slt_bit_s = res_s[WIDTH-1] ^ ovf_s;
      if (cmd_r == CMD_SLT) begin
         fin_result_s = {{(WIDTH-1){1'b0}}, slt_bit_s};
         fin_zero_s   = ~slt_bit_s;
      end else begin
         fin_result_s = res_s;
         fin_zero_s   = ~zacc_r;
      end
   end

   // Command latch, carry/zero chain capture and registered response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_r        <= 3'b000;
         invtb_r      <= 1'b0;
         carry_r      <= 1'b0;
         zacc_r       <= 1'b0;
         cmsb_r       <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= '0;
         rsp_zero_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  cmd_r   <= req_cmd;
                  invtb_r <= cmd_inverts_b(req_cmd);
                  carry_r <= 1'b0;
                  zacc_r  <= 1'b0;
                  cmsb_r  <= 1'b0;
               end
            end
            RUN: begin
               carry_r <= sl_cout;
               zacc_r  <= sl_zout;
               if (last_s) begin
                  cmsb_r <= sl_cin;
               end
            end
            DONE: begin
               // First DONE cycle loads the response; it then holds until accepted.
               if (!rsp_valid_r) begin
                  rsp_valid_r  <= 1'b1;
                  rsp_result_r <= fin_result_s;
                  rsp_zero_r   <= fin_zero_s;
               end else if (rsp_ready) begin
                  rsp_valid_r  <= 1'b0;
                  rsp_result_r <= '0;
                  rsp_zero_r   <= 1'b0;
               end
            end
            default: begin
               rsp_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SERIAL_FLAGS_EN
   logic rsp_carry_r;
   logic rsp_ovf_r;

   // Exported flags, loaded together with the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_carry_r <= 1'b0;
         rsp_ovf_r   <= 1'b0;
      end else if ((state_r == DONE) && !rsp_valid_r) begin
         rsp_carry_r <= ((cmd_r == CMD_ADD) || (cmd_r == CMD_SUB)) ? carry_r : 1'b0;
         rsp_ovf_r   <= ovf_s;
      end else if ((state_r == DONE) && rsp_ready) begin
         rsp_carry_r <= 1'b0;
         rsp_ovf_r   <= 1'b0;
      end else begin
         rsp_carry_r <= rsp_carry_r;
         rsp_ovf_r   <= rsp_ovf_r;
      end
   end

   assign rsp_carry = rsp_carry_r;
   assign rsp_ovf   = rsp_ovf_r;
`endif

   assign req_ready  = (state_r == IDLE);
   assign rsp_valid  = rsp_valid_r;
   assign rsp_result = rsp_result_r;
   assign rsp_zero   = rsp_zero_r;

endmodule
